// File: rtl/img_pingpong_bank_if.sv
// Fill-stream and dual-address read bus of the ping/pong image store.
// The master side is the producer/consumer pair; the slave side is the bank itself.
interface img_pingpong_bank_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                       wr_valid;
  logic                       wr_ready;
  logic [DATA_W-1:0]          wr_data;
  logic                       rd_release;
  logic                       rd_full;
  logic                       rd_en;
  logic [ADDR_W-1:0]          addr1;
  logic [ADDR_W-1:0]          addr2;
  logic [NUM_CH*2*DATA_W-1:0] dout;
  logic                       dout_valid;

  modport master (
    output wr_valid, wr_data, rd_release, rd_en, addr1, addr2,
    input  wr_ready, rd_full, dout, dout_valid
  );

  modport slave (
    input  wr_valid, wr_data, rd_release, rd_en, addr1, addr2,
    output wr_ready, rd_full, dout, dout_valid
  );
endinterface

// File: rtl/img_pingpong_bank.sv
// Double-buffered NUM_CH x DEPTH image store: one bank fills from a valid/ready
// stream while the other serves two read addresses per cycle to every channel.
module img_pingpong_bank #(
  parameter int NUM_CH = 16,
  parameter int DEPTH  = 195,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  img_pingpong_bank_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OUT_W = NUM_CH * 2 * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_WD = ADDR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [ADDR_W-1:0] wd_cnt_q, wd_cnt_d;
  logic              rd_full_q, rd_full_d;
  logic              wr_ready_q, wr_ready_d;
  logic [OUT_W-1:0]  dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  logic              accept_s;
  logic              swap_s;
  logic              rd_bank_s;
  logic [ADDR_W-1:0] addr1_s;
  logic [ADDR_W-1:0] addr2_s;
  logic              in_range1_s;
  logic              in_range2_s;

  // One RAM per bank per channel; contents are deliberately not reset.
  logic [DATA_W-1:0] mem_q [2][NUM_CH][DEPTH];

  assign addr1_s     = bus.addr1;
  assign addr2_s     = bus.addr2;
  assign in_range1_s = ({1'b0, addr1_s} < DEPTH_X);
  assign in_range2_s = ({1'b0, addr2_s} < DEPTH_X);
  assign rd_bank_s   = ~wr_bank_q;
  assign accept_s    = bus.wr_valid && wr_ready_q;
  assign swap_s      = (state_q == ST_FULL) && (!rd_full_q || bus.rd_release);

  // Fill FSM, bank toggle and read-bank ownership next-state.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    ch_cnt_d  = ch_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          if (wd_cnt_q == LAST_WD) begin
            wd_cnt_d = '0;
            if (ch_cnt_q == LAST_CH) begin
              state_d = ST_FULL;
            end else begin
              ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
          end else begin
            wd_cnt_d = wd_cnt_q + ADDR_W'(1);
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_FULL: begin
        if (swap_s) begin
          state_d   = ST_FILL;
          wr_bank_d = ~wr_bank_q;
          ch_cnt_d  = '0;
          wd_cnt_d  = '0;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d  = ST_FILL;
        ch_cnt_d = '0;
        wd_cnt_d = '0;
      end
    endcase

    // A swap coincident with release keeps rd_full set: the new image replaces the old.
    if (swap_s) begin
      rd_full_d = 1'b1;
    end else if (bus.rd_release && rd_full_q) begin
      rd_full_d = 1'b0;
    end else begin
      rd_full_d = rd_full_q;
    end

    wr_ready_d = (state_d == ST_FILL);
  end

  // Read path next-state: both ports of every channel from the read bank.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = bus.rd_en && rd_full_q;
    if (bus.rd_en) begin
      if (rd_full_q) begin
        for (int c = 0; c < NUM_CH; c++) begin
          dout_d[(2*c)*DATA_W +: DATA_W] =
            in_range1_s ? mem_q[rd_bank_s][CH_W'(c)][addr1_s] : {DATA_W{1'b0}};
          dout_d[(2*c+1)*DATA_W +: DATA_W] =
            in_range2_s ? mem_q[rd_bank_s][CH_W'(c)][addr2_s] : {DATA_W{1'b0}};
        end
      end else begin
        dout_d = '0;
      end
    end else begin
      dout_d = dout_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      wr_bank_q    <= 1'b0;
      ch_cnt_q     <= '0;
      wd_cnt_q     <= '0;
      rd_full_q    <= 1'b0;
      wr_ready_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      ch_cnt_q     <= ch_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      rd_full_q    <= rd_full_d;
      wr_ready_q   <= wr_ready_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Fill write port; the read bank is never the write bank, so no collision handling.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_bank_q][ch_cnt_q][wd_cnt_q] <= bus.wr_data;
    end
  end

  assign bus.wr_ready   = wr_ready_q;
  assign bus.rd_full    = rd_full_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule
